// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT input-reordering stage: bank states,
// frame-error bit masks and the frame-length limits.
package idct_pkg;

  // Life cycle of one ping-pong bank.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_st_e;

  // Frame error bits: bit0 = length/sop fault, bit1 = upstream error.
  localparam int ERR_LEN_BIT = 0;
  localparam int ERR_UP_BIT  = 1;
  localparam logic [1:0] ERR_LEN_MASK = 2'b01;
  localparam logic [1:0] ERR_UP_MASK  = 2'b10;

  // Largest supported frame and width of the frame-length ports.
  localparam int MAX_POINTS = 2048;
  localparam int W_PTS      = 12;

endpackage

// File: rtl/idct_pre_rev_ram.sv
// One frame bank: a single write port and two synchronous read ports, built
// as two mirrored 1W1R memories that always receive the same write.
module idct_pre_rev_ram #(
  parameter int wData = 24,
  parameter int wAddr = 11
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [wAddr-1:0]     i_waddr,
  input  logic [2*wData-1:0]   i_wdata,
  input  logic                 i_re,
  input  logic [wAddr-1:0]     i_raddr_a,
  input  logic [wAddr-1:0]     i_raddr_b,
  output logic [2*wData-1:0]   o_rdata_a,
  output logic [2*wData-1:0]   o_rdata_b
);

  logic [2*wData-1:0] r_mem_a [2**wAddr];
  logic [2*wData-1:0] r_mem_b [2**wAddr];

  // Mirrored write into both copies.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem_a[i_waddr] <= i_wdata;
      r_mem_b[i_waddr] <= i_wdata;
    end
  end

  // Registered reads; outputs hold whenever no read is enabled.
  always_ff @(posedge clk) begin
    if (i_re) begin
      o_rdata_a <= r_mem_a[i_raddr_a];
      o_rdata_b <= r_mem_b[i_raddr_b];
    end
  end

endmodule

// File: rtl/idct_pre_rev.sv
// IDCT input-reordering stage. A frame D(1..N) is written in natural order
// into one of two banks; the other bank drains as pairs D(k) / D(N+2-k),
// with the reversed lanes zero on the first beat.
//
// Handshake (both sides, ready latency 0): a beat transfers on a rising
// clock edge where valid and ready are both high. The source side keeps
// data and flags stable while source_valid is high and source_ready is low.
module idct_pre_rev
  import idct_pkg::*;
#(
  parameter int wData = 24,
  parameter int wAddr = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic [1:0]        sink_error,
  input  logic              sink_sop,
  input  logic              sink_eop,
  input  logic [wData-1:0]  sink_real,
  input  logic [wData-1:0]  sink_imag,
  input  logic [W_PTS-1:0]  fftpts_in,
  output logic              source_valid,
  input  logic              source_ready,
  output logic [1:0]        source_error,
  output logic              source_sop,
  output logic              source_eop,
  output logic [wData-1:0]  source_real,
  output logic [wData-1:0]  source_imag,
  output logic [wData-1:0]  source_real_rev,
  output logic [wData-1:0]  source_imag_rev,
  output logic [W_PTS-1:0]  fftpts_out
);

  localparam int DW = 2 * wData;

  // Per-bank bookkeeping.
  bank_st_e          r_st  [2];
  logic [W_PTS-1:0]  r_n   [2];
  logic [1:0]        r_err [2];

  logic              r_run;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [wAddr-1:0]  r_wr_cnt;
  logic [wAddr-1:0]  r_rd_k;

  // Output-stage registers.
  logic              r_src_valid;
  logic              r_src_sop;
  logic              r_src_eop;
  logic              r_src_first;
  logic              r_src_bank;
  logic [1:0]        r_src_err;
  logic [W_PTS-1:0]  r_src_n;

  // ---------------- write side ----------------
  bank_st_e          w_wr_st;
  logic              w_acc;
  logic              w_wr_start;
  logic              w_wr_cont;
  logic              w_wr_en;
  logic              w_commit;
  logic [wAddr-1:0]  w_wr_addr;
  logic [W_PTS-1:0]  w_wr_n;
  logic              w_len_bad;
  logic [1:0]        w_err_base;
  logic [1:0]        w_err_new;

  assign w_wr_st    = r_st[r_wr_sel];
  assign sink_ready = r_run & ((w_wr_st == BANK_EMPTY) | (w_wr_st == BANK_FILLING));
  assign w_acc      = sink_valid & sink_ready;
  // A sop always (re)starts the frame; other beats only count while FILLING,
  // so stray beats into an EMPTY bank are accepted and dropped.
  assign w_wr_start = w_acc & sink_sop;
  assign w_wr_cont  = w_acc & ~sink_sop & (w_wr_st == BANK_FILLING);
  assign w_wr_en    = w_wr_start | w_wr_cont;
  assign w_commit   = w_wr_en & sink_eop;
  assign w_wr_addr  = sink_sop ? '0 : r_wr_cnt;
  assign w_wr_n     = sink_sop ? fftpts_in : r_n[r_wr_sel];
  assign w_len_bad  = (W_PTS'(w_wr_addr) != (w_wr_n - W_PTS'(1)));
  // A restart inside a FILLING bank is itself a sop fault.
  assign w_err_base = w_wr_start ? ((w_wr_st == BANK_FILLING) ? ERR_LEN_MASK : 2'b00)
                                 : r_err[r_wr_sel];
  assign w_err_new  = w_err_base | sink_error |
                      ((w_commit & w_len_bad) ? ERR_LEN_MASK : 2'b00);

  // ---------------- read side ----------------
  bank_st_e          w_rd_st;
  logic              w_en;
  logic              w_issue;
  logic              w_rd_last;
  logic [W_PTS-1:0]  w_rd_n;
  logic [wAddr-1:0]  w_rev_addr;
  logic              w_drain_done;

  assign w_rd_st      = r_st[r_rd_sel];
  assign w_en         = ~r_src_valid | source_ready;
  assign w_issue      = w_en & ((w_rd_st == BANK_FULL) | (w_rd_st == BANK_DRAINING));
  assign w_rd_n       = r_n[r_rd_sel];
  assign w_rd_last    = (W_PTS'(r_rd_k) == (w_rd_n - W_PTS'(1)));
  // Modulo-N arithmetic: N is a power of two, so k=1 maps to address 0.
  assign w_rev_addr   = (w_rd_n[wAddr-1:0] - r_rd_k) & (w_rd_n[wAddr-1:0] - 1'b1);
  assign w_drain_done = r_src_valid & source_ready & r_src_eop;

  // ---------------- banks ----------------
  logic [DW-1:0] w_rd_a [2];
  logic [DW-1:0] w_rd_b [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    idct_pre_rev_ram #(.wData(wData), .wAddr(wAddr)) u_ram (
      .clk       (clk),
      .i_we      (w_wr_en & (r_wr_sel == 1'(g))),
      .i_waddr   (w_wr_addr),
      .i_wdata   ({sink_real, sink_imag}),
      .i_re      (w_issue & (r_rd_sel == 1'(g))),
      .i_raddr_a (r_rd_k),
      .i_raddr_b (w_rev_addr),
      .o_rdata_a (w_rd_a[g]),
      .o_rdata_b (w_rd_b[g])
    );
  end

  // Enable input acceptance one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Bank state machines; write and read transitions touch disjoint states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        r_st[b]  <= BANK_EMPTY;
        r_n[b]   <= '0;
        r_err[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_en && (r_wr_sel == 1'(b))) begin
          r_st[b]  <= w_commit ? BANK_FULL : BANK_FILLING;
          r_err[b] <= w_err_new;
          if (w_wr_start) r_n[b] <= fftpts_in;
        end
        if (w_issue && (r_rd_sel == 1'(b)) && (w_rd_st == BANK_FULL))
          r_st[b] <= BANK_DRAINING;
        if (w_drain_done && (r_src_bank == 1'(b)))
          r_st[b] <= BANK_EMPTY;
      end
    end
  end

  // Write address counter and write-target bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_wr_sel <= 1'b0;
    end else begin
      if (w_wr_en)  r_wr_cnt <= w_wr_addr + 1'b1;
      if (w_commit) r_wr_sel <= ~r_wr_sel;
    end
  end

  // Read address stage: moves to the other bank right after the last issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_k   <= '0;
      r_rd_sel <= 1'b0;
    end else if (w_issue) begin
      if (w_rd_last) begin
        r_rd_k   <= '0;
        r_rd_sel <= ~r_rd_sel;
      end else begin
        r_rd_k   <= r_rd_k + 1'b1;
      end
    end
  end

  // Output stage registers, aligned with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_valid <= 1'b0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
      r_src_first <= 1'b0;
      r_src_bank  <= 1'b0;
      r_src_err   <= '0;
      r_src_n     <= '0;
    end else if (w_en) begin
      r_src_valid <= w_issue;
      r_src_sop   <= w_issue & (r_rd_k == '0);
      r_src_eop   <= w_issue & w_rd_last;
      if (w_issue) begin
        r_src_first <= (r_rd_k == '0);
        r_src_bank  <= r_rd_sel;
        r_src_err   <= r_err[r_rd_sel];
        r_src_n     <= w_rd_n;
      end
    end
  end

  logic [DW-1:0] w_main;
  logic [DW-1:0] w_rev;
  assign w_main = w_rd_a[r_src_bank];
  assign w_rev  = w_rd_b[r_src_bank];

  assign source_valid    = r_src_valid;
  assign source_sop      = r_src_sop;
  assign source_eop      = r_src_eop;
  assign source_error    = r_src_valid ? r_src_err : 2'b00;
  assign fftpts_out      = r_src_n;
  assign source_real     = r_src_valid ? w_main[DW-1:wData] : '0;
  assign source_imag     = r_src_valid ? w_main[wData-1:0]  : '0;
  assign source_real_rev = (r_src_valid & ~r_src_first) ? w_rev[DW-1:wData] : '0;
  assign source_imag_rev = (r_src_valid & ~r_src_first) ? w_rev[wData-1:0]  : '0;

endmodule

// File: tb/tb_idct_pre_rev.sv
// Bench for idct_pre_rev: directed frames, an expected-beat queue filled by
// the frame driver, and a monitor that pops and compares on every transfer.
module tb_idct_pre_rev;

  localparam int WD = 24;
  localparam int VW = 4 * WD + 2 + 2 + 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            sink_valid, sink_ready, sink_sop, sink_eop;
  logic [1:0]      sink_error;
  logic [WD-1:0]   sink_real, sink_imag;
  logic [11:0]     fftpts_in;
  logic            source_valid, source_ready, source_sop, source_eop;
  logic [1:0]      source_error;
  logic [WD-1:0]   source_real, source_imag, source_real_rev, source_imag_rev;
  logic [11:0]     fftpts_out;

  idct_pre_rev #(.wData(WD), .wAddr(11)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sink_valid      (sink_valid),
    .sink_ready      (sink_ready),
    .sink_error      (sink_error),
    .sink_sop        (sink_sop),
    .sink_eop        (sink_eop),
    .sink_real       (sink_real),
    .sink_imag       (sink_imag),
    .fftpts_in       (fftpts_in),
    .source_valid    (source_valid),
    .source_ready    (source_ready),
    .source_error    (source_error),
    .source_sop      (source_sop),
    .source_eop      (source_eop),
    .source_real     (source_real),
    .source_imag     (source_imag),
    .source_real_rev (source_real_rev),
    .source_imag_rev (source_imag_rev),
    .fftpts_out      (fftpts_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [VW-1:0] exp_q[$];
  logic [WD-1:0] got_rev[$];
  logic [47:0]   model_mem [2][2048];
  int model_wr   = 0;
  int eop_cnt    = 0;
  int ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = toggle

  function automatic logic [VW-1:0] out_vec();
    return {source_real, source_imag, source_real_rev, source_imag_rev,
            source_sop, source_eop, source_error, fftpts_out};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // source_ready pattern, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       source_ready = 1'b0;
      1:       source_ready = 1'b1;
      default: source_ready = ~source_ready;
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  logic [VW-1:0] prev_vec;
  logic          prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_while_stalled", {source_valid, out_vec()}, {1'b1, prev_vec});
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h required none", out_vec());
        end else begin
          check("beat", out_vec(), exp_q.pop_front());
        end
        got_rev.push_back(source_real_rev);
      end
      prev_stall = source_valid && !source_ready;
      prev_vec   = out_vec();
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic sop, input logic eop, input logic [WD-1:0] re,
                           input logic [WD-1:0] im, input logic [1:0] er, input logic [11:0] pts);
    int guard;
    @(negedge clk);
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
    sink_real = re; sink_imag = im; sink_error = er; fftpts_in = pts;
    guard = 0;
    while (!sink_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!sink_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL sink_ready_timeout: got 0 required 1");
    end
    @(posedge clk);
  endtask

  task automatic idle_sink();
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
  endtask

  // Sends nbeats of a frame declaring length n and queues the n expected beats.
  task automatic send_frame(input int n, input int nbeats, input int rbase, input int ibase,
                            input int eb, input logic [1:0] ev);
    logic [1:0]    e_err;
    logic [WD-1:0] re, im;
    logic [47:0]   mv, rv;
    e_err = (nbeats != n) ? 2'b01 : 2'b00;
    for (int k = 1; k <= nbeats; k++) begin
      re = WD'(rbase + k);
      im = (ibase == 0) ? '0 : WD'(ibase + k);
      if (k == eb) e_err |= ev;
      send_beat(k == 1, k == nbeats, re, im, (k == eb) ? ev : 2'b00, 12'(n));
      model_mem[model_wr][k-1] = {re, im};
    end
    eop_cnt++;
    #1 idle_sink();
    for (int k = 1; k <= n; k++) begin
      mv = model_mem[model_wr][k-1];
      rv = (k == 1) ? 48'd0 : model_mem[model_wr][(n - (k - 1)) & (n - 1)];
      exp_q.push_back({mv, rv, k == 1, k == n, e_err, 12'(n)});
    end
    model_wr ^= 1;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_complete", 128'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [WD-1:0] tbl [8];
    int base;
    tbl = '{24'd0, 24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2};
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 2048; a++) model_mem[b][a] = '0;
    idle_sink();
    sink_real = '0; sink_imag = '0; fftpts_in = '0; source_ready = 1'b1;

    // Reset state and sink_ready release timing.
    repeat (3) @(negedge clk);
    check("reset_outputs", {sink_ready, source_valid, out_vec()}, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); check("ready_low_at_release", sink_ready, 0);
    @(negedge clk); check("ready_after_release", sink_ready, 1);

    // Stray beats into an EMPTY bank are accepted and dropped.
    send_beat(1'b0, 1'b0, 24'd99, 24'd99, 2'b00, 12'd8);
    send_beat(1'b0, 1'b1, 24'd98, 24'd98, 2'b00, 12'd8);
    #1 idle_sink();

    // N=8, D=1..8: latency and reversed-lane table.
    got_rev.delete();
    send_frame(8, 8, 0, 0, 0, 2'b00);
    @(negedge clk); check("latency_t1_no_valid", source_valid, 0);
    @(negedge clk); check("latency_t2_valid_sop", {source_valid, source_sop}, 2'b11);
    wait_drain();
    check("rev_count", 128'(got_rev.size()), 8);
    for (int i = 0; i < 8; i++)
      if (i < got_rev.size()) check("rev_table", got_rev[i], tbl[i]);

    // Same frame with source_ready toggling every cycle.
    ready_mode = 2;
    send_frame(8, 8, 0, 0, 0, 2'b00);
    wait_drain();
    ready_mode = 1;

    // Three N=16 frames while the output is stalled.
    ready_mode = 0;
    base = eop_cnt;
    fork
      begin
        send_frame(16, 16, 10, 20, 0, 2'b00);
        send_frame(16, 16, 30, 40, 0, 2'b00);
        send_frame(16, 16, 50, 60, 0, 2'b00);
      end
      begin
        int g = 0;
        while (eop_cnt < base + 2 && g < 3000) begin
          @(negedge clk);
          g++;
        end
        @(negedge clk); check("ready_low_both_full", sink_ready, 0);
        repeat (4) @(negedge clk);
        check("ready_stays_low", sink_ready, 0);
        ready_mode = 1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
          check("contiguous_drain", source_valid, 1);
          if (i == 15) check("ready_before_free", sink_ready, 0);
          if (i == 16) check("ready_after_free", sink_ready, 1);
          @(negedge clk);
        end
      end
    join
    wait_drain();

    // N=16 then N=8: fftpts_out and reversed lanes follow each frame.
    send_frame(16, 16, 100, 200, 0, 2'b00);
    send_frame(8, 8, 300, 400, 0, 2'b00);
    wait_drain();

    // Short frame (eop on beat 6) and upstream error on beat 3.
    send_frame(8, 6, 500, 600, 0, 2'b00);
    wait_drain();
    send_frame(8, 8, 700, 800, 3, 2'b10);
    wait_drain();

    // Reset while one frame drains and the next one fills.
    send_frame(16, 16, 900, 1000, 0, 2'b00);
    send_beat(1'b1, 1'b0, 24'd1901, 24'd1902, 2'b00, 12'd8);
    for (int i = 0; i < 3; i++)
      send_beat(1'b0, 1'b0, 24'(1910 + i), 24'(1920 + i), 2'b00, 12'd8);
    #1 check("mid_drain_active", source_valid, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("reset_mid_outputs", {sink_ready, source_valid, out_vec()}, 0);
    exp_q.delete();
    model_wr = 0;
    idle_sink();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); check("ready_low_at_rerelease", sink_ready, 0);
    @(negedge clk); check("ready_after_rerelease", sink_ready, 1);
    send_frame(8, 8, 1100, 1200, 0, 2'b00);
    wait_drain();
    repeat (10) @(negedge clk);
    check("no_residue", 128'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
